// File: rtl/uart8_stream_bridge_pkg.sv
// Shared types for the Uart8 client-side stream bridge.
package uart8_pkg;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } tx_state_t;
endpackage

// File: rtl/uart8_stream_bridge_if.sv
// Byte-stream side of the bridge: TX stream in, RX stream out.
interface uart8_stream_bridge_if;
  import uart8_pkg::*;
  logic [UART_DATA_W-1:0] sTxData;
  logic                   sTxValid;
  logic                   sTxReady;
  logic [UART_DATA_W-1:0] mRxData;
  logic                   mRxValid;
  logic                   mRxReady;

  modport master (output sTxData, sTxValid, mRxReady,
                  input  sTxReady, mRxData, mRxValid);
  modport slave  (input  sTxData, sTxValid, mRxReady,
                  output sTxReady, mRxData, mRxValid);
endinterface

// File: rtl/uart8_stream_bridge_fifo.sv
// Byte FIFO with a registered head: head is valid the cycle after the
// entry lands, so the RX stream data is a flop, not a RAM read.
module byte_fifo
  import uart8_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   push,
  input  logic                   pop,
  input  logic [UART_DATA_W-1:0] wrData,
  output logic [UART_DATA_W-1:0] head,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wrPtr, rdPtr;
  logic [AW:0]            count;
  logic                   doPush, doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still take a push
  assign doPush = push & (~full | doPop);

  // storage, no reset needed
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  // pointers, occupancy and the registered head
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      if (doPush && !doPop)      count <= count + (AW+1)'(1);
      else if (doPop && !doPush) count <= count - (AW+1)'(1);
      // the pushed byte becomes head when nothing else remains ahead of it
      if (doPush && (doPop ? (count == (AW+1)'(1)) : empty)) head <= wrData;
      else if (doPop)                                       head <= mem[rdPtr + AW'(1)];
    end
  end
endmodule

// File: rtl/uart8_stream_bridge.sv
// Client-side bridge between a valid/ready byte stream and the Uart8
// rx/tx handshake. Uart8 status inputs are asynchronous and synchronized here.
module uart8_stream_bridge
  import uart8_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   enable,
  uart8_stream_bridge_if.slave   strm,
  input  logic                   clearFlags,
  output logic                   rxOverflow,
  output logic                   rxFrameErr,
  output logic                   uartRxEn,
  input  logic                   uartRxDone,
  input  logic                   uartRxErr,
  input  logic [UART_DATA_W-1:0] uartRxData,
  output logic                   uartTxEn,
  output logic                   uartTxStart,
  output logic [UART_DATA_W-1:0] uartTxData,
  input  logic                   uartTxBusy
);
  logic [2:0]             syncIn, syncOut;
  logic                   doneSync, errSync, busySync, doneQ, rxEdge;
  logic [SYNC_STAGES:0]   warm;
  logic                   syncReady;
  logic                   rxPush, rxPop, rxFull, rxEmpty;
  logic                   txPush, txPop, txFull, txEmpty;
  logic [UART_DATA_W-1:0] rxHead, txHead;
  tx_state_t              state, stateNext;

  assign syncIn = {uartTxBusy, uartRxErr, uartRxDone};

  genvar g;
  for (g = 0; g < SYNC_STAGES; g++) begin : gSync
    logic [2:0] q;
    if (g == 0) begin : gFirst
      // first synchronizer stage samples the asynchronous inputs
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) q <= '0;
        else         q <= syncIn;
      end
    end else begin : gNext
      // further synchronizer stages
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) q <= '0;
        else         q <= gSync[g-1].q;
      end
    end
  end
  assign syncOut  = gSync[SYNC_STAGES-1].q;
  assign doneSync = syncOut[0];
  assign errSync  = syncOut[1];
  assign busySync = syncOut[2];

  // warm-up shifter: synchronized status is untrusted until the chain has
  // refilled after reset (a Uart8 frame may still be in flight)
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) warm <= '0;
    else         warm <= {warm[SYNC_STAGES-1:0], 1'b1};
  end
  assign syncReady = warm[SYNC_STAGES];

  // rxDone edge-detect flop and registered enables
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      doneQ    <= 1'b0;
      uartRxEn <= 1'b0;
      uartTxEn <= 1'b0;
    end else begin
      doneQ    <= doneSync;
      uartRxEn <= enable;
      uartTxEn <= enable;
    end
  end
  assign rxEdge = doneSync & ~doneQ;

  // RX: one capture decision per rxDone edge
  assign rxPop  = ~rxEmpty & strm.mRxReady;
  assign rxPush = rxEdge & ~errSync & (~rxFull | rxPop);

  // sticky flags; a set event outranks a clear in the same cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rxOverflow <= 1'b0;
      rxFrameErr <= 1'b0;
    end else begin
      if (rxEdge & errSync)                        rxFrameErr <= 1'b1;
      else if (clearFlags)                         rxFrameErr <= 1'b0;
      if (rxEdge & ~errSync & rxFull & ~rxPop)     rxOverflow <= 1'b1;
      else if (clearFlags)                         rxOverflow <= 1'b0;
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) uRxFifo (
    .clk(clk), .resetN(resetN), .push(rxPush), .pop(rxPop),
    .wrData(uartRxData), .head(rxHead), .full(rxFull), .empty(rxEmpty)
  );
  assign strm.mRxData  = rxHead;
  assign strm.mRxValid = ~rxEmpty;

  // TX: ready held low during reset and for the first cycle after it
  assign strm.sTxReady = ~txFull & warm[0];
  assign txPush        = strm.sTxValid & strm.sTxReady;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) uTxFifo (
    .clk(clk), .resetN(resetN), .push(txPush), .pop(txPop),
    .wrData(strm.sTxData), .head(txHead), .full(txFull), .empty(txEmpty)
  );

  // TX FSM state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  // TX FSM next state; START holds until Uart8 reports busy, even if disabled
  always_comb begin
    stateNext = state;
    txPop     = 1'b0;
    unique case (state)
      IDLE: if (!txEmpty && enable && !busySync && syncReady) begin
        txPop     = 1'b1;
        stateNext = START;
      end
      START: if (busySync)  stateNext = SEND;
      SEND:  if (!busySync) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  assign uartTxStart = (state == START);

  // byte to Uart8, latched on IDLE exit and held through the frame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)    uartTxData <= '0;
    else if (txPop) uartTxData <= txHead;
  end
endmodule

// File: tb/tb_uart8_stream_bridge.sv
// Bench: behavioural Uart8 stand-in plus queue-based expectations.
module tb_uart8_stream_bridge;
  import uart8_pkg::*;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       enable = 1'b0;
  logic       clearFlags = 1'b0;
  logic       rxOverflow, rxFrameErr, uartRxEn, uartTxEn, uartTxStart;
  logic       uartRxDone = 1'b0;
  logic       uartRxErr = 1'b0;
  logic [7:0] uartRxData = 8'h00;
  logic [7:0] uartTxData;
  logic       uartTxBusy = 1'b0;

  uart8_stream_bridge_if strm();

  uart8_stream_bridge #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .strm(strm),
    .clearFlags(clearFlags), .rxOverflow(rxOverflow), .rxFrameErr(rxFrameErr),
    .uartRxEn(uartRxEn), .uartRxDone(uartRxDone), .uartRxErr(uartRxErr),
    .uartRxData(uartRxData), .uartTxEn(uartTxEn), .uartTxStart(uartTxStart),
    .uartTxData(uartTxData), .uartTxBusy(uartTxBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Uart8 transmitter stand-in: accepts a byte on txStart, stays busy a while
  bit         txStall = 1'b0;
  int         busyMin = 2, busyMax = 8, busyLeft = 0;
  logic [7:0] sentQ[$];
  int         startRises = 0;
  logic       startPrev = 1'b0;
  always @(negedge clk) begin
    if (uartTxStart && !startPrev) startRises++;
    startPrev = uartTxStart;
    if (uartTxBusy) begin
      if (busyLeft > 0) busyLeft--;
      else uartTxBusy = 1'b0;
    end else if (uartTxStart && !txStall) begin
      sentQ.push_back(uartTxData);
      uartTxBusy = 1'b1;
      busyLeft = $urandom_range(busyMax, busyMin);
    end
  end

  // RX consumer: sole driver of mRxReady, fixed or random per cycle
  bit rdyRand = 1'b0;
  bit rdyFixed = 1'b1;
  always @(posedge clk) begin
    #1;
    strm.mRxReady = rdyRand ? 1'($urandom_range(1, 0)) : rdyFixed;
  end

  logic [7:0] rxGot[$];
  always @(negedge clk)
    if (resetN && strm.mRxValid && strm.mRxReady) rxGot.push_back(strm.mRxData);

  task automatic sendByte(input logic [7:0] d);
    int t = 0;
    strm.sTxData  = d;
    strm.sTxValid = 1'b1;
    while (!strm.sTxReady && t < 500) begin tick(); t++; end
    chk("txAccept", {31'd0, strm.sTxReady}, 32'd1);
    tick();
    strm.sTxValid = 1'b0;
  endtask

  task automatic rxEvent(input logic [7:0] d, input logic err);
    uartRxData = d;
    uartRxErr  = err;
    uartRxDone = 1'b1;
    repeat (5) tick();
    uartRxDone = 1'b0;
    repeat (6) tick();
  endtask

  task automatic waitSent(input int n);
    int t = 0;
    while (sentQ.size() < n && t < 3000) begin tick(); t++; end
    chk("txDrainCount", sentQ.size(), n);
  endtask

  task automatic waitRx(input int n);
    int t = 0;
    while (rxGot.size() < n && t < 3000) begin tick(); t++; end
    repeat (5) tick();
    chk("rxDrainCount", rxGot.size(), n);
  endtask

  task automatic chkOutputsZero(input string tag);
    chk({tag, "_sTxReady"},   {31'd0, strm.sTxReady}, 0);
    chk({tag, "_mRxValid"},   {31'd0, strm.mRxValid}, 0);
    chk({tag, "_mRxData"},    {24'd0, strm.mRxData}, 0);
    chk({tag, "_txStart"},    {31'd0, uartTxStart}, 0);
    chk({tag, "_txData"},     {24'd0, uartTxData}, 0);
    chk({tag, "_txEn"},       {31'd0, uartTxEn}, 0);
    chk({tag, "_rxEn"},       {31'd0, uartRxEn}, 0);
    chk({tag, "_rxOverflow"}, {31'd0, rxOverflow}, 0);
    chk({tag, "_rxFrameErr"}, {31'd0, rxFrameErr}, 0);
  endtask

  logic [7:0] expQ[$];
  logic [7:0] d;
  logic       e;
  bit         anyErr;
  int         accepted, t, bad;

  initial begin
    strm.sTxData  = 8'h00;
    strm.sTxValid = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    chkOutputsZero("rst");
    resetN = 1'b1;
    repeat (5) tick();

    // first push into empty TX FIFO: start two cycles after sTxValid is presented
    strm.sTxData  = 8'h55;
    strm.sTxValid = 1'b1;
    tick();
    strm.sTxValid = 1'b0;
    chk("lat1_start", {31'd0, uartTxStart}, 0);
    tick();
    chk("lat2_start", {31'd0, uartTxStart}, 1);
    chk("lat2_data",  {24'd0, uartTxData}, 32'h55);
    sendByte(8'hA3);
    waitSent(2);
    chk("tx0", {24'd0, sentQ[0]}, 32'h55);
    chk("tx1", {24'd0, sentQ[1]}, 32'hA3);
    repeat (30) tick();
    chk("txStartRises", startRises, 2);
    sentQ.delete();

    // disabled + stalled: FIFO fills at 16 and holds the 17th off
    enable = 1'b0;
    txStall = 1'b1;
    repeat (3) tick();
    expQ.delete();
    for (int i = 0; i < 17; i++) expQ.push_back(8'($urandom));
    accepted = 0;
    strm.sTxValid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      strm.sTxData = expQ[i];
      if (!strm.sTxReady) break;
      tick();
      accepted++;
    end
    chk("fullAccepted", accepted, 16);
    repeat (3) tick();
    chk("fullReadyLow", {31'd0, strm.sTxReady}, 0);
    chk("fullNoneSent", sentQ.size(), 0);
    enable = 1'b1;
    txStall = 1'b0;
    sendByte(expQ[16]);
    waitSent(17);
    for (int i = 0; i < 17; i++) chk("fullOrder", {24'd0, sentQ[i]}, {24'd0, expQ[i]});
    repeat (30) tick();
    sentQ.delete();

    // random TX traffic with random gaps and busy lengths
    busyMin = 2; busyMax = 10;
    expQ.delete();
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      expQ.push_back(d);
      repeat ($urandom_range(3, 0)) tick();
      sendByte(d);
    end
    waitSent(24);
    for (int i = 0; i < 24; i++) chk("txRand", {24'd0, sentQ[i]}, {24'd0, expQ[i]});
    repeat (30) tick();
    sentQ.delete();

    // RX: extremes, consumer always ready
    rdyFixed = 1'b1;
    rxGot.delete();
    rxEvent(8'h00, 1'b0);
    rxEvent(8'hFF, 1'b0);
    waitRx(2);
    chk("rx00", {24'd0, rxGot[0]}, 32'h00);
    chk("rxFF", {24'd0, rxGot[1]}, 32'hFF);
    chk("rxIdleValid", {31'd0, strm.mRxValid}, 0);

    // RX overflow: 17 events, nothing consumed
    rdyFixed = 1'b0;
    tick();
    rxGot.delete();
    expQ.delete();
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      expQ.push_back(d);
      rxEvent(d, 1'b0);
    end
    chk("ovfValid",    {31'd0, strm.mRxValid}, 1);
    chk("ovfHead",     {24'd0, strm.mRxData}, {24'd0, expQ[0]});
    chk("ovfFlag",     {31'd0, rxOverflow}, 1);
    chk("ovfFrameErr", {31'd0, rxFrameErr}, 0);
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    chk("ovfCleared",  {31'd0, rxOverflow}, 0);
    rdyFixed = 1'b1;
    waitRx(16);
    for (int i = 0; i < 16; i++) chk("ovfOrder", {24'd0, rxGot[i]}, {24'd0, expQ[i]});

    // RX frame error: byte dropped, flag set
    rxGot.delete();
    rxEvent(8'h7E, 1'b1);
    repeat (5) tick();
    chk("ferrNoPush", rxGot.size(), 0);
    chk("ferrValid",  {31'd0, strm.mRxValid}, 0);
    chk("ferrFlag",   {31'd0, rxFrameErr}, 1);
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    chk("ferrCleared", {31'd0, rxFrameErr}, 0);

    // RX random data/errors with a randomly stalling consumer
    rxGot.delete();
    expQ.delete();
    anyErr = 1'b0;
    rdyRand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      e = ($urandom_range(5, 0) == 0);
      if (!e) expQ.push_back(d);
      anyErr |= e;
      rxEvent(d, e);
    end
    rdyRand = 1'b0;
    rdyFixed = 1'b1;
    tick();
    waitRx(expQ.size());
    for (int i = 0; i < expQ.size(); i++) chk("rxRand", {24'd0, rxGot[i]}, {24'd0, expQ[i]});
    chk("rxRandFrameErr", {31'd0, rxFrameErr}, {31'd0, anyErr});
    chk("rxRandOverflow", {31'd0, rxOverflow}, 0);
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;

    // reset during SEND: outputs clear, next byte waits for the old frame
    sentQ.delete();
    busyMin = 40; busyMax = 40;
    sendByte(8'hC1);
    t = 0;
    while (!(uartTxBusy && !uartTxStart) && t < 200) begin tick(); t++; end
    chk("rstInSend", {31'd0, uartTxBusy}, 1);
    resetN = 1'b0;
    #1;
    chkOutputsZero("midRst");
    tick();
    resetN = 1'b1;
    busyMin = 3; busyMax = 3;
    sendByte(8'h3C);
    bad = 0;
    t = 0;
    while (uartTxBusy && t < 200) begin
      if (uartTxStart) bad = 1;
      tick();
      t++;
    end
    chk("rstNoStartWhileBusy", bad, 0);
    waitSent(2);
    chk("rstOldByte", {24'd0, sentQ[0]}, 32'hC1);
    chk("rstNewByte", {24'd0, sentQ[1]}, 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
